// File: rtl/ifu_axil_fetch.sv
// Instruction-fetch AXI4-Lite read master: one AR/R per instruction, handed to the IDU over
// valid/ready, then waits for write-back to supply the next PC. Watchdog aborts stalled fetches.
module ifu_axil_fetch #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h8000_0000),
   parameter int unsigned        TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pc_valid,
   input  logic [ADDR_W-1:0]   pc_in,
   output logic                pc_ready,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [DATA_W-1:0]   inst,
   output logic [ADDR_W-1:0]   inst_pc,
   output logic                inst_err,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

   typedef enum logic [2:0] {StBoot, StAddr, StData, StOut, StWait} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                drain_q, drain_d;
   logic [DATA_W-1:0]   inst_q, inst_d;
   logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
   logic                inst_err_q, inst_err_d;
   logic                timeout;

   // Write channels are never used by the fetch path.
   logic unused_inputs;
   assign unused_inputs = ^{awready, wready, bresp, bvalid};

   assign awaddr  = '0;
   assign awvalid = 1'b0;
   assign wdata   = '0;
   assign wstrb   = '0;
   assign wvalid  = 1'b0;
   assign bready  = 1'b0;

   // A pending dropped beat keeps the next AR off the bus and keeps rready high.
   assign arvalid    = (state_q == StAddr) && !drain_q;
   assign rready     = (state_q == StData) || drain_q;
   assign inst_valid = (state_q == StOut);
   assign pc_ready   = (state_q == StWait);
   assign araddr     = arvalid ? pc_q : '0;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_err   = inst_err_q;

   assign timeout = (cnt_q == 8'(TIMEOUT));

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      drain_d    = drain_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      inst_err_d = inst_err_q;

      if (drain_q && rvalid) begin
         drain_d = 1'b0;
      end

      unique case (state_q)
         StBoot: begin
            state_d = StAddr;
            cnt_d   = '0;
         end
         StAddr: begin
            cnt_d = cnt_q + 8'd1;
            if (arvalid && arready) begin
               state_d = StData;
            end else if (timeout) begin
               state_d    = StOut;
               inst_d     = NOP;
               inst_pc_d  = pc_q;
               inst_err_d = 1'b1;
            end
         end
         StData: begin
            cnt_d = cnt_q + 8'd1;
            if (rvalid) begin
               state_d    = StOut;
               inst_d     = (rresp == 2'b00) ? rdata : NOP;
               inst_pc_d  = pc_q;
               inst_err_d = (rresp != 2'b00);
            end else if (timeout) begin
               state_d    = StOut;
               inst_d     = NOP;
               inst_pc_d  = pc_q;
               inst_err_d = 1'b1;
               drain_d    = 1'b1;
            end
         end
         StOut: begin
            if (inst_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (pc_valid) begin
               pc_d    = pc_in;
               cnt_d   = '0;
               state_d = StAddr;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StBoot;
         pc_q       <= RESET_PC;
         cnt_q      <= '0;
         drain_q    <= 1'b0;
         inst_q     <= '0;
         inst_pc_q  <= '0;
         inst_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         drain_q    <= drain_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         inst_err_q <= inst_err_d;
      end
   end

endmodule
